// File: rtl/groestl_sched_pkg.sv
// groestl_sched_pkg: shared state type, nonce width and popcount helper for the nonce scheduler
package groestl_sched_pkg;
  localparam int NONCE_W = 32;
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} state_t;
  function automatic logic [3:0] popcount(input logic [7:0] v);
    popcount = '0;
    for (int i = 0; i < 8; i++) popcount = popcount + 4'(v[i]);
  endfunction
endpackage

// File: rtl/groestl_gold_fifo.sv
// groestl_gold_fifo: synchronous first-word-fall-through FIFO for golden nonces
module groestl_gold_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic wr_en, rd_en;
  // a full FIFO refuses the push even when a pop frees a slot in the same cycle
  assign wr_en = push && count < CW'(DEPTH);
  assign rd_en = pop && count != '0;
  assign dout = count == '0 ? '0 : mem[rd];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (wr_en) wr <= wr == AW'(DEPTH - 1) ? '0 : wr + 1'b1;
      if (rd_en) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wr] <= din;
endmodule

// File: rtl/groestl_nonce_scheduler.sv
// groestl_nonce_scheduler: sweeps a nonce range across hasher lanes round-robin and queues winning nonces
module groestl_nonce_scheduler
  import groestl_sched_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic [NONCE_W-1:0]           nonce_first,
  input  logic [NONCE_W-1:0]           nonce_last,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_CORES-1:0]         job_valid,
  input  logic [NUM_CORES-1:0]         job_ready,
  output logic [NONCE_W-1:0]           job_nonce,
  input  logic [NUM_CORES-1:0]         res_valid,
  input  logic [NUM_CORES-1:0]         res_hit,
  input  logic [NONCE_W*NUM_CORES-1:0] res_nonce,
  output logic                         gold_valid,
  output logic [NONCE_W-1:0]           gold_nonce,
  input  logic                         gold_pop,
  output logic [31:0]                  hash_count,
  output logic                         overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  logic [NONCE_W-1:0] next_n, last_n, push_d;
  logic [NONCE_W-1:0] hold_nonce [NUM_CORES];
  logic [NUM_CORES-1:0] oh, hold_full, hit, drop, mv;
  logic [2:0] rr, lane, pick;
  logic [7:0] outstanding;
  logic [3:0] retired;
  logic [CW-1:0] fifo_count;
  logic found, held, push, offer, accept, fin, launch;
  assign hit = res_valid & res_hit;
  assign drop = hit & hold_full;
  assign retired = popcount(8'(res_valid));
  assign launch = state == IDLE && start;
  assign push = held && fifo_count < CW'(FIFO_DEPTH);
  assign busy = state != IDLE;
  assign gold_valid = fifo_count != '0;
  // first ready lane at or after rr, else the first ready lane below rr
  always_comb begin
    found = 1'b0;
    pick = '0;
    oh = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (!found && job_ready[i] && 3'(i) >= rr) begin
        found = 1'b1;
        pick = 3'(i);
        oh[i] = 1'b1;
      end
    for (int i = 0; i < NUM_CORES; i++)
      if (!found && job_ready[i]) begin
        found = 1'b1;
        pick = 3'(i);
        oh[i] = 1'b1;
      end
  end
  always_comb begin
    held = 1'b0;
    mv = '0;
    push_d = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (!held && hold_full[i]) begin
        held = 1'b1;
        mv[i] = 1'b1;
        push_d = hold_nonce[i];
      end
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    offer = 1'b0;
    accept = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE: if (start) state_n = nonce_first > nonce_last ? DRAIN : DISPATCH;
      DISPATCH: begin
        accept = |(job_valid & job_ready);
        offer = ~|job_valid && found && !stop;
        if (stop || (accept && next_n == last_n)) state_n = DRAIN;
      end
      DRAIN: begin
        fin = outstanding == '0 && ~|hold_full;
        if (fin) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      job_valid <= '0;
      job_nonce <= '0;
      lane <= '0;
      rr <= '0;
      next_n <= '0;
      last_n <= '0;
      outstanding <= '0;
      hash_count <= '0;
      overflow <= 1'b0;
      hold_full <= '0;
    end else begin
      done <= fin;
      if (launch) begin
        next_n <= nonce_first;
        last_n <= nonce_last;
      end else if (accept && next_n != last_n) next_n <= next_n + 1'b1;
      if (offer) begin
        job_valid <= oh;
        job_nonce <= next_n;
        lane <= pick;
      end else if (accept || (state == DISPATCH && stop)) job_valid <= '0;
      if (accept) rr <= lane == 3'(NUM_CORES - 1) ? '0 : lane + 3'd1;
      outstanding <= outstanding + 8'(accept) - 8'(retired);
      hash_count <= launch ? '0 : hash_count + 32'(retired);
      overflow <= launch ? 1'b0 : overflow | (|drop);
      hold_full <= (hold_full & ~(push ? mv : '0)) | (hit & ~hold_full);
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CORES; i++)
      if (hit[i] && !hold_full[i]) hold_nonce[i] <= res_nonce[NONCE_W*i +: NONCE_W];
  groestl_gold_fifo #(.DEPTH(FIFO_DEPTH), .W(NONCE_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(push_d),
    .pop(gold_pop),
    .dout(gold_nonce),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_groestl_nonce_scheduler.sv
// tb_groestl_nonce_scheduler: table-driven sweeps, directed corner sequences and randomized sweeps vs a lane/range model
module tb_groestl_nonce_scheduler;
  localparam int N = 4;
  logic clk = 0, reset = 1, start = 0, stop = 0, gold_pop = 0;
  logic [31:0] nonce_first = 0, nonce_last = 0;
  logic busy, done, gold_valid, overflow;
  logic [N-1:0] job_valid, job_ready = 0, res_valid = 0, res_hit = 0;
  logic [31:0] job_nonce, gold_nonce, hash_count;
  logic [32*N-1:0] res_nonce = 0;
  int n_cmp = 0, n_fail = 0, model_rr = 0;

  typedef struct { logic [31:0] first, last; logic [N-1:0] mask; int jobs; } vec_t;
  vec_t tbl[5];

  groestl_nonce_scheduler #(.NUM_CORES(N), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .nonce_first(nonce_first), .nonce_last(nonce_last),
    .busy(busy), .done(done), .job_valid(job_valid), .job_ready(job_ready),
    .job_nonce(job_nonce), .res_valid(res_valid), .res_hit(res_hit),
    .res_nonce(res_nonce), .gold_valid(gold_valid), .gold_nonce(gold_nonce),
    .gold_pop(gold_pop), .hash_count(hash_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1; start = 0; stop = 0; gold_pop = 0; job_ready = 0; res_valid = 0; res_hit = 0;
    tick;
    reset = 0;
    model_rr = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_job_valid"}, job_valid, 0);
    check({tag, "_job_nonce"}, job_nonce, 0);
    check({tag, "_gold_valid"}, gold_valid, 0);
    check({tag, "_gold_nonce"}, gold_nonce, 0);
    check({tag, "_hash_count"}, hash_count, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  // lanes in mask are pipelined and always ready; each accepted job retires 3 cycles later
  task automatic run_sweep(input logic [31:0] first, input logic [31:0] last, input logic [N-1:0] mask,
                           output int jobs, output int seq_err, output int lane_err, output int dones, output int done_cyc);
    logic [N-1:0] sched [300];
    int lane, exp_lane;
    for (int c = 0; c < 300; c++) sched[c] = '0;
    jobs = 0; seq_err = 0; lane_err = 0; dones = 0; done_cyc = -1;
    nonce_first = first; nonce_last = last; job_ready = mask; start = 1;
    tick;
    start = 0;
    for (int c = 1; c < 296; c++) begin
      res_valid = sched[c];
      if (|(job_valid & job_ready)) begin
        lane = 0;
        for (int i = 0; i < N; i++) if (job_valid[i]) lane = i;
        exp_lane = -1;
        for (int k = 0; k < N; k++)
          if (exp_lane < 0 && mask[(model_rr + k) % N]) exp_lane = (model_rr + k) % N;
        if (lane != exp_lane) lane_err++;
        if (job_nonce != first + 32'(jobs)) seq_err++;
        model_rr = (lane + 1) % N;
        jobs++;
        sched[c + 3] = sched[c + 3] | job_valid;
      end
      tick;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c > done_cyc + 3) break;
    end
    res_valid = 0;
    job_ready = 0;
  endtask

  initial begin
    int jobs, seq_err, lane_err, dones, done_cyc, acc, len, issued, res_n, oh_err, hd, mism;
    logic [31:0] first, last;
    logic [N-1:0] rdy, rv, rh;
    int cnt[N];
    logic [31:0] ln[N];
    bit lh[N];
    logic [31:0] exp_hits[$], got[$];

    tbl[0] = '{32'h10, 32'h13, 4'b1111, 4};
    tbl[1] = '{32'h5, 32'h4, 4'b1111, 0};
    tbl[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'b0001, 2};
    tbl[3] = '{32'h0, 32'h0, 4'b0100, 1};
    tbl[4] = '{32'd100, 32'd106, 4'b1010, 7};

    tick;
    do_reset;
    check_idle_outputs("reset");

    for (int t = 0; t < 5; t++) begin
      run_sweep(tbl[t].first, tbl[t].last, tbl[t].mask, jobs, seq_err, lane_err, dones, done_cyc);
      check($sformatf("v%0d_jobs", t), jobs, tbl[t].jobs);
      check($sformatf("v%0d_nonce_seq", t), seq_err, 0);
      check($sformatf("v%0d_rr_lane", t), lane_err, 0);
      check($sformatf("v%0d_done_pulses", t), dones, 1);
      check($sformatf("v%0d_hash_count", t), hash_count, tbl[t].jobs);
      check($sformatf("v%0d_busy_end", t), busy, 0);
      if (tbl[t].jobs == 0) check($sformatf("v%0d_done_latency", t), done_cyc, 1);
    end

    // two hits on the same cycle leave in lane-index order
    do_reset;
    res_valid = 4'b1010; res_hit = 4'b1010;
    res_nonce = '0; res_nonce[63:32] = 32'hA; res_nonce[127:96] = 32'hB;
    tick;
    res_valid = 0; res_hit = 0;
    check("dual_held_not_yet", gold_valid, 0);
    tick;
    check("dual_gold_valid", gold_valid, 1);
    check("dual_head_a", gold_nonce, 32'hA);
    tick;
    gold_pop = 1; tick; gold_pop = 0;
    check("dual_head_b", gold_nonce, 32'hB);
    gold_pop = 1; tick; gold_pop = 0;
    check("dual_empty", gold_valid, 0);
    check("dual_overflow", overflow, 0);
    check("dual_hash_count", hash_count, 2);

    // fill FIFO, then one held hit and one lost hit on lane 0
    do_reset;
    for (int k = 0; k < 6; k++) begin
      res_valid = 4'b0001; res_hit = 4'b0001; res_nonce[31:0] = 32'h100 + 32'(k);
      tick;
      res_valid = 0; res_hit = 0;
      if (k == 4) check("ovf_held_no_overflow", overflow, 0);
      tick;
    end
    check("ovf_overflow_set", overflow, 1);
    check("ovf_head", gold_nonce, 32'h100);
    gold_pop = 1; tick; gold_pop = 0;
    tick;
    for (int k = 1; k < 5; k++) begin
      check($sformatf("ovf_pop%0d", k), gold_nonce, 32'h100 + 32'(k));
      gold_pop = 1; tick; gold_pop = 0;
    end
    check("ovf_drained", gold_valid, 0);
    check("ovf_hash_count", hash_count, 6);

    // stop while an offer is pending with two jobs outstanding
    do_reset;
    nonce_first = 0; nonce_last = 100; start = 1; job_ready = 4'b0011;
    tick;
    start = 0;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      if (job_valid != 0 && acc == 2) begin
        job_ready = 0;
        break;
      end
      if (|(job_valid & job_ready)) acc++;
      tick;
    end
    check("stop_accepts", acc, 2);
    tick; tick;
    check("stop_offer_held", job_valid, 4'b0001);
    check("stop_offer_nonce", job_nonce, 2);
    stop = 1; tick; stop = 0;
    check("stop_withdrawn", job_valid, 0);
    check("stop_busy", busy, 1);
    tick; tick;
    check("stop_no_early_done", done, 0);
    res_valid = 4'b0011;
    tick;
    res_valid = 0;
    check("stop_done_wait", done, 0);
    tick;
    check("stop_done", done, 1);
    check("stop_busy_fall", busy, 0);
    tick;
    check("stop_done_once", done, 0);
    check("stop_hash_count", hash_count, 2);

    // reset mid-sweep with a golden nonce queued
    do_reset;
    nonce_first = 0; nonce_last = 50; start = 1; job_ready = 4'b1111;
    tick;
    start = 0;
    res_valid = 4'b0100; res_hit = 4'b0100; res_nonce[95:64] = 32'h77;
    tick;
    res_valid = 0; res_hit = 0;
    tick; tick; tick;
    check("mid_gold_valid", gold_valid, 1);
    check("mid_busy", busy, 1);
    do_reset;
    check_idle_outputs("midreset");

    // randomized sweeps: one job per lane at a time, random latency, hits and ready gaps
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 24);
      first = (r == 0) ? 32'hFFFF_FFFF - 32'(len) + 1 : 32'($urandom_range(0, 32'hFFFF_0000));
      last = first + 32'(len) - 1;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; ln[i] = 0; lh[i] = 0; end
      exp_hits.delete(); got.delete();
      issued = 0; seq_err = 0; dones = 0; res_n = 0; oh_err = 0; hd = -1;
      nonce_first = first; nonce_last = last; start = 1;
      tick;
      start = 0;
      for (int c = 0; c < 2000; c++) begin
        rv = 0; rh = 0; rdy = 0;
        for (int i = 0; i < N; i++) begin
          if (cnt[i] == 1) begin
            rv[i] = 1; rh[i] = lh[i]; res_nonce[32*i +: 32] = ln[i];
            if (lh[i]) exp_hits.push_back(ln[i]);
            res_n++;
          end
          rdy[i] = cnt[i] == 0 && $urandom_range(0, 4) != 0;
        end
        res_valid = rv; res_hit = rh; job_ready = rdy;
        if (job_valid != 0 && !$onehot(job_valid)) oh_err++;
        for (int i = 0; i < N; i++) if (cnt[i] > 0) cnt[i]--;
        for (int i = 0; i < N; i++)
          if (job_valid[i] && rdy[i]) begin
            if (job_nonce != first + 32'(issued)) seq_err++;
            issued++;
            cnt[i] = $urandom_range(2, 6);
            ln[i] = job_nonce;
            lh[i] = $urandom_range(0, 2) == 0;
          end
        gold_pop = gold_valid;
        if (gold_valid) got.push_back(gold_nonce);
        tick;
        if (done) begin dones++; hd = c; end
        if (hd >= 0 && c > hd + 2) break;
      end
      res_valid = 0; res_hit = 0; job_ready = 0;
      for (int c = 0; c < 20; c++) begin
        gold_pop = gold_valid;
        if (gold_valid) got.push_back(gold_nonce);
        tick;
      end
      gold_pop = 0;
      exp_hits.sort(); got.sort();
      mism = 0;
      foreach (got[k]) if (k >= exp_hits.size() || got[k] != exp_hits[k]) mism++;
      check($sformatf("rnd%0d_issued", r), issued, len);
      check($sformatf("rnd%0d_nonce_seq", r), seq_err, 0);
      check($sformatf("rnd%0d_onehot", r), oh_err, 0);
      check($sformatf("rnd%0d_retired", r), res_n, len);
      check($sformatf("rnd%0d_hash_count", r), hash_count, len);
      check($sformatf("rnd%0d_done_pulses", r), dones, 1);
      check($sformatf("rnd%0d_busy_end", r), busy, 0);
      check($sformatf("rnd%0d_overflow", r), overflow, 0);
      check($sformatf("rnd%0d_gold_count", r), got.size(), exp_hits.size());
      check($sformatf("rnd%0d_gold_set", r), mism, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
